// File: rtl/mem_byte_arbiter_if.sv
// Bus bundle for mem_byte_arbiter.
// Groups the IF, DM and byte-memory signals.
// Ports: if_* (fetch read), dm_* (data r/w),
//   mem_* (byte memory), busy (arbiter status).
// slave = arbiter side, master = requester/memory side.
interface mem_byte_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [7:0]        mem_rdata;
   logic              busy;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_ready,
      output dm_rdata, dm_ready,
      output mem_addr, mem_wdata, mem_we, mem_re,
      output busy
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_ready,
      input  dm_rdata, dm_ready,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      input  busy
   );
endinterface

// File: rtl/mem_byte_arbiter.sv
// Shares one byte-wide memory between IF and DM.
// Each word moves as 4 big-endian byte cycles.
// Ports: clk, rst (async, active-high),
//   bus (mem_byte_arbiter_if.slave): IF/DM
//   request ports, byte memory port, busy.
module mem_byte_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int NBYTES = DATA_W / 8
) (
   input logic               clk,
   input logic               rst,
   mem_byte_arbiter_if.slave bus
);
   localparam int CW = $clog2(NBYTES);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rbuf_q, rbuf_d;
   logic              last_dm_q, last_dm_d;
   logic              done_q, done_d;

   logic              if_vld;
   logic              dm_vld;
   logic              grant_dm;
   logic [ADDR_W-1:0] sel_addr;
   logic [CW+2:0]     bsel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         base_q    <= '0;
         wdata_q   <= '0;
         rbuf_q    <= '0;
         last_dm_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         base_q    <= base_d;
         wdata_q   <= wdata_d;
         rbuf_q    <= rbuf_d;
         last_dm_q <= last_dm_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      we_d      = we_q;
      base_d    = base_q;
      wdata_d   = wdata_q;
      rbuf_d    = rbuf_q;
      last_dm_d = last_dm_q;
      done_d    = 1'b0;

      bus.if_rdata  = '0;
      bus.if_ready  = 1'b0;
      bus.dm_rdata  = '0;
      bus.dm_ready  = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.busy      = (state_q != IDLE);

      // The requester just served still holds req
      // during the first IDLE cycle; mask it once.
      if_vld = bus.if_req & ~(done_q & ~owner_q);
      dm_vld = bus.dm_req & ~(done_q & owner_q);
      // DM wins unless it won last time and IF waits.
      grant_dm = dm_vld & ~(last_dm_q & if_vld);
      sel_addr = grant_dm ? bus.dm_addr : bus.if_addr;
      // Byte NBYTES-1-cnt of the word, MSB first.
      bsel = {CW'(NBYTES - 1) - cnt_q, 3'b000};

      unique case (state_q)
         IDLE: begin
            if (if_vld | dm_vld) begin
               state_d   = XFER;
               cnt_d     = '0;
               owner_d   = grant_dm;
               last_dm_d = grant_dm;
               we_d      = grant_dm & bus.dm_we;
               base_d    = sel_addr & ~ADDR_W'(NBYTES - 1);
               wdata_d   = bus.dm_wdata;
            end
         end
         XFER: begin
            bus.mem_addr  = base_q + ADDR_W'(cnt_q);
            bus.mem_re    = ~we_q;
            bus.mem_we    = we_q;
            bus.mem_wdata = wdata_q[bsel +: 8];
            if (!we_q) begin
               rbuf_d = {rbuf_q[DATA_W-9:0], bus.mem_rdata};
            end
            if (cnt_q == CW'(NBYTES - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (owner_q) begin
               bus.dm_ready = 1'b1;
               bus.dm_rdata = rbuf_q;
            end else begin
               bus.if_ready = 1'b1;
               bus.if_rdata = rbuf_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_byte_arbiter.sv
// Directed bench for mem_byte_arbiter.
// Drives IF/DM requests, models the byte memory.
module tb_mem_byte_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic init_mem;

   always #5 clk = ~clk;

   mem_byte_arbiter_if bus ();

   mem_byte_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [0:63];

   assign bus.mem_rdata = mem[bus.mem_addr[5:0]];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 64; i++) begin
            if (i >= 32 && i < 36) mem[i] <= 8'h55;
            else mem[i] <= 8'(i);
         end
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
      end
   end

   int nchk = 0;
   int nerr = 0;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
      end
   endtask

   int          cyc;
   int          ev_own[$];
   int          ev_cyc[$];
   logic [31:0] ev_dat[$];
   logic [31:0] ev_oth[$];
   logic [31:0] amin, amax;
   bit          hold_dm, hold_if;

   task automatic cyc_step();
      @(negedge clk);
      cyc++;
      chk("rdy_excl",
          32'(bus.if_ready & bus.dm_ready), 0);
      chk("strb_excl",
          32'(bus.mem_we & bus.mem_re), 0);
      if (!bus.busy)
         chk("idle_strb",
             32'(bus.mem_we | bus.mem_re), 0);
      if (bus.mem_we | bus.mem_re) begin
         if (bus.mem_addr < amin) amin = bus.mem_addr;
         if (bus.mem_addr > amax) amax = bus.mem_addr;
      end
      if (bus.dm_ready) begin
         ev_own.push_back(1);
         ev_cyc.push_back(cyc);
         ev_dat.push_back(bus.dm_rdata);
         ev_oth.push_back(bus.if_rdata);
      end
      if (bus.if_ready) begin
         ev_own.push_back(0);
         ev_cyc.push_back(cyc);
         ev_dat.push_back(bus.if_rdata);
         ev_oth.push_back(bus.dm_rdata);
      end
   endtask

   task automatic run(input int n);
      logic dr, ir;
      for (int k = 0; k < n; k++) begin
         cyc_step();
         dr = bus.dm_ready & ~hold_dm;
         ir = bus.if_ready & ~hold_if;
         if (dr | ir) begin
            @(posedge clk);
            #1;
            if (dr) bus.dm_req = 1'b0;
            if (ir) bus.if_req = 1'b0;
         end
      end
   endtask

   task automatic begin_test();
      ev_own.delete();
      ev_cyc.delete();
      ev_dat.delete();
      ev_oth.delete();
      cyc  = -1;
      amin = '1;
      amax = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ev(input string tag,
                         input int i,
                         input int own,
                         input int c,
                         input logic [31:0] dat,
                         input bit cd);
      if (i >= ev_own.size()) begin
         chk({tag, "_missing"}, 0, 1);
      end else begin
         chk({tag, "_own"}, ev_own[i], own);
         chk({tag, "_cyc"}, ev_cyc[i], c);
         chk({tag, "_other_rdata"}, ev_oth[i], 0);
         if (cd) chk({tag, "_rdata"}, ev_dat[i], dat);
      end
   endtask

   task automatic chk_word(input string tag,
                           input int a,
                           input logic [31:0] w);
      for (int i = 0; i < 4; i++)
         chk(tag, 32'(mem[a+i]), 32'(w[31-8*i -: 8]));
   endtask

   initial begin
      rst          = 1'b1;
      init_mem     = 1'b1;
      hold_dm      = 1'b0;
      hold_if      = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      init_mem = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_if_ready", 32'(bus.if_ready), 0);
      chk("rst_dm_ready", 32'(bus.dm_ready), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_re", 32'(bus.mem_re), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_dm_rdata", bus.dm_rdata, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // DM write 0x10
      begin_test();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h10;
      bus.dm_wdata = 32'hDEADBEEF;
      run(8);
      chk("t1_nev", ev_own.size(), 1);
      chk_ev("t1", 0, 1, 5, 0, 0);
      chk_word("t1_byte", 16, 32'hDEADBEEF);
      bus.dm_we = 1'b0;

      // IF read back 0x10
      begin_test();
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      run(8);
      chk("t2_nev", ev_own.size(), 1);
      chk_ev("t2", 0, 0, 5, 32'hDEADBEEF, 1);

      // simultaneous requests, DM first
      begin_test();
      bus.dm_req  = 1'b1;
      bus.dm_we   = 1'b0;
      bus.dm_addr = 32'h4;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      run(14);
      chk("t3_nev", ev_own.size(), 2);
      chk_ev("t3_dm", 0, 1, 5, 32'h04050607, 1);
      chk_ev("t3_if", 1, 0, 11, 32'hDEADBEEF, 1);

      // both held: grants alternate
      begin_test();
      hold_dm     = 1'b1;
      hold_if     = 1'b1;
      bus.dm_req  = 1'b1;
      bus.dm_addr = 32'h0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h4;
      run(24);
      @(posedge clk);
      #1;
      bus.dm_req = 1'b0;
      bus.if_req = 1'b0;
      hold_dm    = 1'b0;
      hold_if    = 1'b0;
      run(6);
      chk("t4_nev", ev_own.size(), 4);
      chk_ev("t4_a", 0, 1, 5, 32'h00010203, 1);
      chk_ev("t4_b", 1, 0, 11, 32'h04050607, 1);
      chk_ev("t4_c", 2, 1, 17, 32'h00010203, 1);
      chk_ev("t4_d", 3, 0, 23, 32'h04050607, 1);

      // unaligned write, inputs change mid-transfer
      begin_test();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h1F;
      bus.dm_wdata = 32'h01020304;
      run(2);
      @(posedge clk);
      #1;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = 32'h0;
      bus.dm_wdata = 32'hFFFFFFFF;
      run(6);
      chk("t5_nev", ev_own.size(), 1);
      chk_ev("t5", 0, 1, 5, 0, 0);
      chk("t5_amin", amin, 32'h1C);
      chk("t5_amax", amax, 32'h1F);
      chk_word("t5_byte", 28, 32'h01020304);

      // reset during byte 2 of a write
      begin_test();
      bus.dm_req   = 1'b1;
      bus.dm_we    = 1'b1;
      bus.dm_addr  = 32'h20;
      bus.dm_wdata = 32'hA1B2C3D4;
      run(4);
      chk("t6_addr", bus.mem_addr, 32'h22);
      chk("t6_we_pre", 32'(bus.mem_we), 1);
      rst        = 1'b1;
      bus.dm_req = 1'b0;
      #1;
      chk("t6_busy", 32'(bus.busy), 0);
      chk("t6_we", 32'(bus.mem_we), 0);
      chk("t6_ready", 32'(bus.dm_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(6);
      chk("t6_nev", ev_own.size(), 0);
      chk_word("t6_byte", 32, 32'hA1B25555);

      $display("Simulation finished: %0d checks, %0d errors",
               nchk, nerr);
      $finish;
   end
endmodule
